// File: rtl/turf_register_arbiter_if.sv
// TURF register bus channel. The same bundle carries a requester-to-arbiter
// link and the arbiter-to-target link; master drives the request side.
interface turf_register_arbiter_if;
    logic        en;
    logic        wr;
    logic [27:0] adr;
    logic [31:0] dat_w;
    logic        ack;
    logic [31:0] dat_r;

    modport master (output en, wr, adr, dat_w, input  ack, dat_r);
    modport slave  (input  en, wr, adr, dat_w, output ack, dat_r);
endinterface

// File: rtl/turf_register_arbiter.sv
// Two-requester round-robin arbiter for the TURF register bus with a
// watchdog that force-completes transactions the target never acks.
//
// state | meaning
// IDLE  | no transaction; pick a requester and latch its fields
// ISSUE | one-cycle en_o strobe on the bus; watchdog counter cleared
// WAIT  | waiting for ack_i; watchdog counting
// RESP  | one-cycle ack and read data back to the granted requester
module turf_register_arbiter #(
    parameter int unsigned TIMEOUT      = 64,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    turf_register_arbiter_if.slave         m0,
    turf_register_arbiter_if.slave         m1,
    turf_register_arbiter_if.master        bus,
    output logic [1:0]                     grant_o,
    output logic                           timeout_o,
    input  logic                           timeout_clr_i
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_m1_q, last_m1_d;
    logic        wr_q, wr_d;
    logic [27:0] adr_q, adr_d;
    logic [31:0] wdat_q, wdat_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] m0_dat_q, m0_dat_d;
    logic [31:0] m1_dat_q, m1_dat_d;
    logic        timeout_q, timeout_d;

    logic        req_any;
    logic        pick_m1;
    logic        bus_done;
    logic        wdog_hit;
    logic        complete;
    logic [31:0] cap_dat;

    // Arbitration decision and completion events for the current cycle.
    // On a tie the requester that did not own the last transaction wins.
    always_comb begin
        req_any  = m0.en | m1.en;
        pick_m1  = m1.en & (~m0.en | ~last_m1_q);
        bus_done = ((state_q == S_ISSUE) || (state_q == S_WAIT)) && bus.ack;
        // A real ack in the final watchdog cycle takes precedence over the timeout.
        wdog_hit = (state_q == S_WAIT) && !bus.ack && (cnt_q == CNT_LAST);
        complete = bus_done | wdog_hit;
        cap_dat  = bus_done ? bus.dat_r : TIMEOUT_DATA;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_any)  state_d = S_ISSUE;
            S_ISSUE: state_d = bus.ack ? S_RESP : S_WAIT;
            S_WAIT:  if (complete) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: bus strobe only in ISSUE, requester ack only in RESP.
    always_comb begin
        bus.en = (state_q == S_ISSUE);
        m0.ack = (state_q == S_RESP) && grant_q[0];
        m1.ack = (state_q == S_RESP) && grant_q[1];
    end

    // Datapath next values: grant/field latch, watchdog, response capture.
    always_comb begin
        grant_d   = grant_q;
        last_m1_d = last_m1_q;
        wr_d      = wr_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        cnt_d     = cnt_q;
        m0_dat_d  = m0_dat_q;
        m1_dat_d  = m1_dat_q;
        timeout_d = timeout_q;

        if ((state_q == S_IDLE) && req_any) begin
            grant_d = pick_m1 ? 2'b10 : 2'b01;
            wr_d    = pick_m1 ? m1.wr    : m0.wr;
            adr_d   = pick_m1 ? m1.adr   : m0.adr;
            wdat_d  = pick_m1 ? m1.dat_w : m0.dat_w;
        end

        if (state_q == S_ISSUE) begin
            cnt_d = '0;
        end else if (state_q == S_WAIT) begin
            cnt_d = cnt_q + 16'd1;
        end

        // Response data is written straight into the owner's hold register
        // so it is already valid during the RESP ack cycle.
        if (complete) begin
            if (grant_q[1]) begin
                m1_dat_d = cap_dat;
            end else begin
                m0_dat_d = cap_dat;
            end
        end

        if (state_q == S_RESP) begin
            grant_d   = 2'b00;
            last_m1_d = grant_q[1];
        end

        if (wdog_hit) begin
            timeout_d = 1'b1;
        end else if (timeout_clr_i) begin
            timeout_d = 1'b0;
        end
    end

    // Datapath registers; last owner resets to m1 so m0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q   <= 2'b00;
            last_m1_q <= 1'b1;
            wr_q      <= 1'b0;
            adr_q     <= '0;
            wdat_q    <= '0;
            cnt_q     <= '0;
            m0_dat_q  <= '0;
            m1_dat_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            grant_q   <= grant_d;
            last_m1_q <= last_m1_d;
            wr_q      <= wr_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            cnt_q     <= cnt_d;
            m0_dat_q  <= m0_dat_d;
            m1_dat_q  <= m1_dat_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.wr    = wr_q;
    assign bus.adr   = adr_q;
    assign bus.dat_w = wdat_q;
    assign m0.dat_r  = m0_dat_q;
    assign m1.dat_r  = m1_dat_q;
    assign grant_o   = grant_q;
    assign timeout_o = timeout_q;

endmodule

// File: doc/turf_register_arbiter.md
Name: turf_register_arbiter

Overview:
- Shares the single TURF register bus (en/wr/adr/dat/ack) between two requesters: m0 (host/PCIe bridge) and m1 (on-chip sequencer).
- Round-robin arbitration, one outstanding transaction at a time.
- Converts a held request into a single-cycle bus strobe and returns a one-cycle ack plus read data to the granted requester.
- Bus watchdog: a target that never acks is completed with TIMEOUT_DATA and a sticky error flag is set.

Parameters:
TIMEOUT, 64, cycles in WAIT with no ack_i before forced completion (range 2..65535)
TIMEOUT_DATA, 32'hDEADBEEF, read data returned on a timed-out transaction

Ports:
clk  input  1  single clock
rst_n  input  1  asynchronous, active-low reset
m0_en_i  input  1  m0 request; held high until m0_ack_o
m0_wr_i  input  1  m0 write(1)/read(0)
m0_adr_i  input  28  m0 address
m0_dat_i  input  32  m0 write data
m0_ack_o  output  1  m0 completion, one-cycle pulse
m0_dat_o  output  32  m0 read data, valid when m0_ack_o is high
m1_en_i, m1_wr_i, m1_adr_i, m1_dat_i, m1_ack_o, m1_dat_o  as for m0
en_o  input-to-target strobe  1  one-cycle bus enable (output)
wr_o  output  1  latched write flag
adr_o  output  28  latched address
dat_o  output  32  latched write data
ack_i  input  1  target ack; may arrive in the same cycle as en_o or later
dat_i  input  32  target read data, sampled with ack_i
grant_o  output  2  one-hot current owner; 00 when idle
timeout_o  output  1  sticky watchdog flag
timeout_clr_i  input  1  clears timeout_o

Behaviour:
- Reset (async assert, sync release):
  - state IDLE.
  - en_o, wr_o, m*_ack_o, timeout_o and grant_o all 0.
  - adr_o, dat_o and m*_dat_o all 0.
  - last_grant = m1, so m0 wins the first tie.
  - Reset mid-transaction drops the transaction; no ack is issued.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If either en_i is high, grant one requester: if both request, grant the one not equal to last_grant.
  - Latch the granted requester's wr/adr/dat into wr_o/adr_o/dat_o, set grant_o, go to ISSUE.
  - ack_i in IDLE is ignored.
- ISSUE: en_o = 1 for exactly this cycle; clear the watchdog counter.
  - ack_i = 1 this cycle: capture dat_i, go to RESP.
  - Otherwise: go to WAIT.
- WAIT: the counter increments each cycle.
  - ack_i = 1: capture dat_i, go to RESP.
  - Counter reaches TIMEOUT-1 with no ack: capture TIMEOUT_DATA, set timeout_o, go to RESP.
  - If ack_i and timeout coincide, ack_i wins and timeout_o is not set.
- RESP:
  - The granted requester's m*_ack_o = 1 for one cycle; its m*_dat_o holds the captured data (register, held until next completion to that requester).
  - The captured data is also valid for writes and is ignored by the requester.
  - last_grant := granted requester; grant_o := 00; go to IDLE.
- Requester rules:
  - Keep en_i, wr_i, adr_i and dat_i stable until ack.
  - Deassert en_i the cycle after ack; en_i still high in IDLE is a new request.
  - The arbiter latches fields in IDLE, so later requester changes do not affect the bus.
- Latency: with the target acking one cycle after en_o, request seen in IDLE at cycle N gives en_o at N+1 and m_ack_o at N+3.
- Non-granted requester: waits, with ack low, until the arbiter returns to IDLE.
- timeout_o: stays 1 until timeout_clr_i. If clear and a new timeout coincide, the set wins.
- At most one transaction is ever outstanding; en_o is never asserted outside ISSUE.

Test Plan:
- m0 read adr 0x0000001, target acks one cycle after en_o with 0x12345678 -> en_o pulses one cycle, m0_ack_o three cycles after request, m0_dat_o = 0x12345678, grant_o = 01 then 00.
- m1 write adr 0x0000002, dat 0xA5A5A5A5, target acks same cycle as en_o -> wr_o = 1, adr_o/dat_o match, m1_ack_o two cycles after request, no second en_o.
- m0 and m1 request simultaneously from reset, held continuously -> grant order m0, m1, m0, m1; each ack goes only to its owner.
- Target never acks, TIMEOUT = 64 -> m0_ack_o at cycle 64 of WAIT, m0_dat_o = 0xDEADBEEF, timeout_o = 1 until timeout_clr_i; the next normal transaction completes correctly.
- rst_n asserted during WAIT -> all outputs 0 immediately; a late ack_i after release is ignored; next request is serviced normally with m0 priority.
- ack_i pulsed while IDLE, and ack_i coinciding with the timeout count -> no spurious m*_ack_o in IDLE; the coincident case returns dat_i and leaves timeout_o = 0.
